// File: rtl/kbd_scancode_assembler.sv
// PS/2 set-2 byte stream to 9-bit {ext, code} key events with make/brakee/seq_err pulses.
// Optional typematic-repeat suppression: define KBD_TYPEMATIC_FILTER_EN.
module kbd_scancode_assembler #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned PAUSE_LEN   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic [8:0] key_Pressed,
    output logic       make,
    output logic       brakee,
    output logic       seq_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam int unsigned PW = $clog2(PAUSE_LEN + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pause_cnt_q, pause_cnt_d;
    logic [8:0]    key_q, key_d;
    logic          make_q, make_d;
    logic          brakee_q, brakee_d;
    logic          seq_err_q, seq_err_d;

    logic          is_status, is_fake, is_prefix, timeout;
    logic          ev_make, ev_brk;
    logic [8:0]    ev_code;

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [8:0]    last_make_q, last_make_d;
    logic          last_valid_q, last_valid_d;
`endif

    assign is_status = (din == 8'h00) || (din == 8'hAA) || (din == 8'hEE) || (din == 8'hFA) ||
                       (din == 8'hFC) || (din == 8'hFE) || (din == 8'hFF);
    assign is_fake   = (din == 8'h12) || (din == 8'h59);
    assign is_prefix = (din == 8'hE0) || (din == 8'hF0) || (din == 8'hE1);
    // A byte arriving on the expiry cycle takes priority over the timeout
    assign timeout   = (state_q != IDLE) && (timer_q == TMAX) && !din_new;

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        key_d       = key_q;
        make_d      = 1'b0;
        brakee_d    = 1'b0;
        seq_err_d   = 1'b0;
        ev_make     = 1'b0;
        ev_brk      = 1'b0;
        ev_code     = '0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        last_make_d  = last_make_q;
        last_valid_d = last_valid_q;
`endif

        if (din_new || state_q == IDLE) begin
            timer_d = '0;
        end else if (timer_q != TMAX) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end

        if (timeout) begin
            state_d     = IDLE;
            pause_cnt_d = '0;
            seq_err_d   = 1'b1;
        end else if (din_new) begin
            case (state_q)
                IDLE: begin
                    if (din == 8'hE0) begin
                        state_d = EXT;
                    end else if (din == 8'hF0) begin
                        state_d = BRK;
                    end else if (din == 8'hE1) begin
                        state_d     = PAUSE;
                        pause_cnt_d = PW'(PAUSE_LEN);
                    end else if (!is_status) begin
                        ev_make = 1'b1;
                        ev_code = {1'b0, din};
                    end
                end
                EXT: begin
                    state_d = IDLE;
                    if (din == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (!is_fake) begin
                        if (din == 8'hE0 || din == 8'hE1) begin
                            seq_err_d = 1'b1;
                        end else begin
                            ev_make = 1'b1;
                            ev_code = {1'b1, din};
                        end
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (is_prefix) begin
                        seq_err_d = 1'b1;
                    end else begin
                        ev_brk  = 1'b1;
                        ev_code = {1'b0, din};
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (!is_fake) begin
                        if (is_prefix) begin
                            seq_err_d = 1'b1;
                        end else begin
                            ev_brk  = 1'b1;
                            ev_code = {1'b1, din};
                        end
                    end
                end
                PAUSE: begin
                    if (pause_cnt_q <= PW'(1)) begin
                        state_d     = IDLE;
                        pause_cnt_d = '0;
                    end else begin
                        pause_cnt_d = pause_cnt_q - PW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef KBD_TYPEMATIC_FILTER_EN
        if (ev_make && !(last_valid_q && last_make_q == ev_code)) begin
            key_d        = ev_code;
            make_d       = 1'b1;
            last_make_d  = ev_code;
            last_valid_d = 1'b1;
        end
        if (ev_brk) begin
            key_d    = ev_code;
            brakee_d = 1'b1;
            if (last_valid_q && last_make_q == ev_code) begin
                last_valid_d = 1'b0;
            end
        end
`else
        if (ev_make) begin
            key_d  = ev_code;
            make_d = 1'b1;
        end
        if (ev_brk) begin
            key_d    = ev_code;
            brakee_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pause_cnt_q <= '0;
            key_q       <= '0;
            make_q      <= 1'b0;
            brakee_q    <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pause_cnt_q <= pause_cnt_d;
            key_q       <= key_d;
            make_q      <= make_d;
            brakee_q    <= brakee_d;
            seq_err_q   <= seq_err_d;
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_make_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_make_q  <= last_make_d;
            last_valid_q <= last_valid_d;
        end
    end
`endif

    assign key_Pressed = key_q;
    assign make        = make_q;
    assign brakee      = brakee_q;
    assign seq_err     = seq_err_q;

endmodule
